// File: rtl/vector_division_sequencer_pkg.sv
// Shared definitions for the vector division sequencer: the default WIDTH define,
// FSM state encodings, component indices and the divide-by-zero saturation value.
`ifndef WIDTH
`define WIDTH 32
`endif

package vector_division_sequencer_pkg;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ISSUE       = 3'd1;
  localparam logic [2:0] S_WAIT_RESULT = 3'd2;
  localparam logic [2:0] S_RELEASE     = 3'd3;
  localparam logic [2:0] S_NEXT        = 3'd4;
  localparam logic [2:0] S_DONE        = 3'd5;

  localparam logic [1:0] COMP_X    = 2'd0;
  localparam logic [1:0] COMP_Y    = 2'd1;
  localparam logic [1:0] COMP_Z    = 2'd2;
  localparam logic [1:0] COMP_NONE = 2'd3;

  // Positive saturation for a zero divisor; negative dividends get its two's complement.
  localparam logic [31:0] DIV_ZERO_SAT = 32'h0FFF_FFFF;

  // Components are always served X first, then Y, then Z.
  function automatic logic [1:0] lowest_pending(input logic [2:0] pend);
    if (pend[0])      return COMP_X;
    else if (pend[1]) return COMP_Y;
    else if (pend[2]) return COMP_Z;
    else              return COMP_NONE;
  endfunction

endpackage

// File: rtl/vector_division_sequencer.sv
// Serialises a masked X/Y/Z fixed-point division through one external signed divider.
// Optional macro DIV_ZERO_BYPASS_EN saturates zero-divisor components without using the divider.
`ifndef WIDTH
`define WIDTH 32
`endif

module vector_division_sequencer
  import vector_division_sequencer_pkg::*;
#(
  parameter int WIDTH    = `WIDTH,
  parameter int MAX_WAIT = 255
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iDividendX,
  input  logic [WIDTH-1:0] iDividendY,
  input  logic [WIDTH-1:0] iDividendZ,
  input  logic [WIDTH-1:0] iDivisorX,
  input  logic [WIDTH-1:0] iDivisorY,
  input  logic [WIDTH-1:0] iDivisorZ,
  input  logic [2:0]       iComponentMask,
  output logic [WIDTH-1:0] oDivDividend,
  output logic [WIDTH-1:0] oDivDivisor,
  output logic             oDivInputReady,
  input  logic             iDivOutputReady,
  input  logic [WIDTH-1:0] iDivQuotient,
  output logic [WIDTH-1:0] oResultX,
  output logic [WIDTH-1:0] oResultY,
  output logic [WIDTH-1:0] oResultZ,
  output logic             oBusy,
  output logic             oDone,
  output logic             oTimeout,
  output logic [2:0]       oState
);

  // Divider handshake: oDivInputReady is a level held from ISSUE until the cycle
  // iDivOutputReady is seen; the next request only starts after iDivOutputReady
  // has returned low, so the two levels never overlap on a new request.

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  logic [2:0]       state_q;
  logic [2:0]       pend_q;
  logic [1:0]       cur_q;
  logic [CW-1:0]    wait_cnt_q;
  logic [WIDTH-1:0] dvd_x_q, dvd_y_q, dvd_z_q;
  logic [WIDTH-1:0] dvs_x_q, dvs_y_q, dvs_z_q;

  logic [1:0]       pick;
  logic [WIDTH-1:0] pick_dvd;
  logic [WIDTH-1:0] pick_dvs;
  logic             bypass;
  logic [WIDTH-1:0] sat_val;
  logic             wait_expired;
  logic             res_we;
  logic [1:0]       res_idx;
  logic [WIDTH-1:0] res_data;

  assign wait_expired = (wait_cnt_q == CW'(MAX_WAIT - 1));

  always_comb begin
    pick     = lowest_pending(pend_q);
    pick_dvd = dvd_x_q;
    pick_dvs = dvs_x_q;
    case (pick)
      COMP_Y: begin
        pick_dvd = dvd_y_q;
        pick_dvs = dvs_y_q;
      end
      COMP_Z: begin
        pick_dvd = dvd_z_q;
        pick_dvs = dvs_z_q;
      end
      default: ;
    endcase
  end

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass  = (pick != COMP_NONE) && (pick_dvs == '0);
  assign sat_val = pick_dvd[WIDTH-1] ? -WIDTH'(DIV_ZERO_SAT) : WIDTH'(DIV_ZERO_SAT);
`else
  assign bypass  = 1'b0;
  assign sat_val = '0;
`endif

  // Single result write port: divider capture, timeout zero, or zero-divisor saturation.
  always_comb begin
    res_we   = 1'b0;
    res_idx  = cur_q;
    res_data = iDivQuotient;
    case (state_q)
      S_WAIT_RESULT: begin
        if (iDivOutputReady) begin
          res_we = 1'b1;
        end else if (wait_expired) begin
          res_we   = 1'b1;
          res_data = '0;
        end
      end
      S_NEXT: begin
        if (bypass) begin
          res_we   = 1'b1;
          res_idx  = pick;
          res_data = sat_val;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      cur_q        <= COMP_X;
      wait_cnt_q   <= '0;
      dvd_x_q      <= '0;
      dvd_y_q      <= '0;
      dvd_z_q      <= '0;
      dvs_x_q      <= '0;
      dvs_y_q      <= '0;
      dvs_z_q      <= '0;
      oDivDividend <= '0;
      oDivDivisor  <= '0;
      oResultX     <= '0;
      oResultY     <= '0;
      oResultZ     <= '0;
      oTimeout     <= 1'b0;
    end else begin
      if (res_we) begin
        case (res_idx)
          COMP_X:  oResultX <= res_data;
          COMP_Y:  oResultY <= res_data;
          COMP_Z:  oResultZ <= res_data;
          default: ;
        endcase
      end

      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            dvd_x_q  <= iDividendX;
            dvd_y_q  <= iDividendY;
            dvd_z_q  <= iDividendZ;
            dvs_x_q  <= iDivisorX;
            dvs_y_q  <= iDivisorY;
            dvs_z_q  <= iDivisorZ;
            pend_q   <= iComponentMask;
            oTimeout <= 1'b0;
            // Unmasked components pass their dividend straight through.
            oResultX <= iComponentMask[0] ? '0 : iDividendX;
            oResultY <= iComponentMask[1] ? '0 : iDividendY;
            oResultZ <= iComponentMask[2] ? '0 : iDividendZ;
            state_q  <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (pick == COMP_NONE) begin
            state_q <= S_DONE;
          end else begin
            pend_q <= pend_q & (pend_q - 3'd1);
            cur_q  <= pick;
            if (!bypass) begin
              oDivDividend <= pick_dvd;
              oDivDivisor  <= pick_dvs;
              state_q      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT_RESULT;
        end
        S_WAIT_RESULT: begin
          if (iDivOutputReady) begin
            state_q <= S_RELEASE;
          end else if (wait_expired) begin
            oTimeout <= 1'b1;
            state_q  <= S_RELEASE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_RELEASE: begin
          if (!iDivOutputReady) state_q <= S_NEXT;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oBusy          = (state_q != S_IDLE);
  assign oDone          = (state_q == S_DONE);
  assign oDivInputReady = (state_q == S_ISSUE) || (state_q == S_WAIT_RESULT);
  assign oState         = state_q;

endmodule

// File: tb/tb_vector_division_sequencer.sv
// Directed bench: the sequencer paired with a behavioural fixed-point divider (SCALE=16)
// of configurable latency, plus a second instance with MAX_WAIT=16 and a silent divider.
module tb_vector_division_sequencer;
  import vector_division_sequencer_pkg::*;

  logic        Clock;
  logic        Reset;
  logic        iStart;
  logic [31:0] iDividendX, iDividendY, iDividendZ;
  logic [31:0] iDivisorX, iDivisorY, iDivisorZ;
  logic [2:0]  iComponentMask;
  logic [31:0] oDivDividend, oDivDivisor;
  logic        oDivInputReady;
  logic        iDivOutputReady;
  logic [31:0] iDivQuotient;
  logic [31:0] oResultX, oResultY, oResultZ;
  logic        oBusy, oDone, oTimeout;
  logic [2:0]  oState;

  logic        t_start;
  logic [31:0] t_dvd, t_dvs;
  logic        t_inrdy;
  logic        t_outrdy;
  logic [31:0] t_quot;
  logic [31:0] t_res_x, t_res_y, t_res_z;
  logic        t_busy, t_done, t_timeout;
  logic [2:0]  t_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;
  int overlap_cnt = 0;
  int rel_cnt  = 0;
  logic mon_prev_inrdy = 1'b0;

  int lat;
  int hold_extra;
  int dcnt;
  int hold;
  logic [1:0]  dstate;
  logic [31:0] a_q, b_q;

  vector_division_sequencer #(.WIDTH(32), .MAX_WAIT(255)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart),
    .iDividendX(iDividendX), .iDividendY(iDividendY), .iDividendZ(iDividendZ),
    .iDivisorX(iDivisorX), .iDivisorY(iDivisorY), .iDivisorZ(iDivisorZ),
    .iComponentMask(iComponentMask),
    .oDivDividend(oDivDividend), .oDivDivisor(oDivDivisor),
    .oDivInputReady(oDivInputReady), .iDivOutputReady(iDivOutputReady),
    .iDivQuotient(iDivQuotient),
    .oResultX(oResultX), .oResultY(oResultY), .oResultZ(oResultZ),
    .oBusy(oBusy), .oDone(oDone), .oTimeout(oTimeout), .oState(oState)
  );

  vector_division_sequencer #(.WIDTH(32), .MAX_WAIT(16)) dut_to (
    .Clock(Clock), .Reset(Reset), .iStart(t_start),
    .iDividendX(iDividendX), .iDividendY(iDividendY), .iDividendZ(iDividendZ),
    .iDivisorX(iDivisorX), .iDivisorY(iDivisorY), .iDivisorZ(iDivisorZ),
    .iComponentMask(iComponentMask),
    .oDivDividend(t_dvd), .oDivDivisor(t_dvs),
    .oDivInputReady(t_inrdy), .iDivOutputReady(t_outrdy),
    .iDivQuotient(t_quot),
    .oResultX(t_res_x), .oResultY(t_res_y), .oResultZ(t_res_z),
    .oBusy(t_busy), .oDone(t_done), .oTimeout(t_timeout), .oState(t_state)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign t_outrdy = 1'b0;
  assign t_quot   = 32'h0;

  // Behavioural Q16.16 signed divider
  function automatic logic [31:0] fx_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (b == 32'h0) return 32'hFFFF_FFFF;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    return 32'((sa <<< 16) / sb);
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      iDivOutputReady <= 1'b0;
      iDivQuotient    <= 32'h0;
      dstate          <= 2'd0;
      dcnt            <= 0;
      hold            <= 0;
    end else begin
      case (dstate)
        2'd0: if (oDivInputReady) begin
          a_q    <= oDivDividend;
          b_q    <= oDivDivisor;
          dcnt   <= 1;
          dstate <= 2'd1;
        end
        2'd1: if (dcnt >= lat) begin
          iDivOutputReady <= 1'b1;
          iDivQuotient    <= fx_div(a_q, b_q);
          hold            <= hold_extra;
          dstate          <= 2'd2;
        end else begin
          dcnt <= dcnt + 1;
        end
        2'd2: if (hold == 0) begin
          iDivOutputReady <= 1'b0;
          dstate          <= 2'd3;
        end else begin
          hold <= hold - 1;
        end
        default: if (!oDivInputReady) dstate <= 2'd0;
      endcase
    end
  end

  // Event monitors on the main instance
  always @(negedge Clock) begin
    if (oDone) done_cnt++;
    if (oDivInputReady && !mon_prev_inrdy) begin
      hs_cnt++;
      if (iDivOutputReady) overlap_cnt++;
    end
    mon_prev_inrdy = oDivInputReady;
    if (oState == S_RELEASE) rel_cnt++;
  end

  // Driver tasks
  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [2:0] m,
                         input logic [31:0] dx, input logic [31:0] vx,
                         input logic [31:0] dy, input logic [31:0] vy,
                         input logic [31:0] dz, input logic [31:0] vz);
    iComponentMask = m;
    iDividendX = dx; iDivisorX = vx;
    iDividendY = dy; iDivisorY = vy;
    iDividendZ = dz; iDivisorZ = vz;
  endtask

  task automatic start(input logic [2:0] m,
                       input logic [31:0] dx, input logic [31:0] vx,
                       input logic [31:0] dy, input logic [31:0] vy,
                       input logic [31:0] dz, input logic [31:0] vz);
    set_ops(m, dx, vx, dy, vy, dz, vz);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int k;
    k = 0;
    while (!oDone && k < max_cycles) begin
      tick();
      k++;
    end
    check(tag, {31'h0, oDone}, 32'h1);
    tick();
  endtask

  int snap_done, snap_hs, snap_ov, snap_rel;
  int rises, k, w, early;
  logic prev;

  initial begin
    Reset = 1'b1;
    iStart = 1'b0;
    t_start = 1'b0;
    lat = 3;
    hold_extra = 0;
    set_ops(3'b000, 0, 0, 0, 0, 0, 0);
    tick(3);
    check("rst_flags", {28'h0, oBusy, oDone, oTimeout, oDivInputReady}, 32'h0);
    check("rst_state", {29'h0, oState}, {29'h0, S_IDLE});
    check("rst_results", oResultX | oResultY | oResultZ, 32'h0);
    check("rst_div_ops", oDivDividend | oDivDivisor, 32'h0);
    Reset = 1'b0;
    tick(2);

    // Three components, short latency
    snap_done = done_cnt; snap_hs = hs_cnt;
    start(3'b111, 32'h0002_0000, 32'h0001_0000, 32'hFFFE_0000, 32'h0001_0000,
          32'h0001_0000, 32'h0002_0000);
    check("t1_busy", {31'h0, oBusy}, 32'h1);
    wait_done("t1_done", 200);
    tick(2);
    check("t1_x", oResultX, 32'h0002_0000);
    check("t1_y", oResultY, 32'hFFFE_0000);
    check("t1_z", oResultZ, 32'h0000_8000);
    check("t1_done_pulses", done_cnt - snap_done, 1);
    check("t1_handshakes", hs_cnt - snap_hs, 3);
    check("t1_idle", {29'h0, oState}, {29'h0, S_IDLE});

    // Long latency, Y unmasked, negative divisor on Z
    lat = 40;
    snap_hs = hs_cnt;
    start(3'b101, 32'h0003_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0004_0000,
          32'h0005_0000, 32'hFFFF_0000);
    wait_done("t2_done", 400);
    tick(2);
    check("t2_x", oResultX, 32'h0001_8000);
    check("t2_y", oResultY, 32'hFFFF_0000);
    check("t2_z", oResultZ, 32'hFFFB_0000);
    check("t2_handshakes", hs_cnt - snap_hs, 2);

    // Only Y divided
    lat = 3;
    snap_hs = hs_cnt;
    start(3'b010, 32'h1234_5678, 32'h0000_0005, 32'h0006_0000, 32'h0003_0000,
          32'h0ABC_DEF0, 32'h0000_0001);
    wait_done("t3_done", 200);
    tick(2);
    check("t3_x", oResultX, 32'h1234_5678);
    check("t3_y", oResultY, 32'h0002_0000);
    check("t3_z", oResultZ, 32'h0ABC_DEF0);
    check("t3_handshakes", hs_cnt - snap_hs, 1);

    // Empty mask: IDLE -> NEXT -> DONE
    start(3'b000, 32'hAAAA_0001, 32'h1, 32'hBBBB_0002, 32'h1, 32'hCCCC_0003, 32'h1);
    check("t4_next", {29'h0, oState}, {29'h0, S_NEXT});
    check("t4_no_done_yet", {31'h0, oDone}, 32'h0);
    tick();
    check("t4_done_cycle2", {31'h0, oDone}, 32'h1);
    tick();
    check("t4_done_one_cycle", {31'h0, oDone}, 32'h0);
    check("t4_idle", {29'h0, oState}, {29'h0, S_IDLE});
    check("t4_results", oResultX ^ oResultY ^ oResultZ, 32'hAAAA_0001 ^ 32'hBBBB_0002 ^ 32'hCCCC_0003);

    // Divider holds its result level 5 extra cycles
    hold_extra = 5;
    snap_rel = rel_cnt; snap_ov = overlap_cnt; snap_hs = hs_cnt;
    start(3'b011, 32'h0004_0000, 32'h0002_0000, 32'h0001_0000, 32'h0004_0000,
          32'h0000_0000, 32'h0000_0001);
    wait_done("t5_done", 200);
    tick(2);
    check("t5_release_cycles", rel_cnt - snap_rel, 12);
    check("t5_overlap", overlap_cnt - snap_ov, 0);
    check("t5_handshakes", hs_cnt - snap_hs, 2);
    check("t5_x", oResultX, 32'h0002_0000);
    check("t5_y", oResultY, 32'h0000_4000);
    hold_extra = 0;

    // Reset while waiting on the Y division
    lat = 40;
    rises = 0; k = 0; prev = 1'b0;
    start(3'b111, 32'h0002_0000, 32'h0001_0000, 32'hFFFE_0000, 32'h0001_0000,
          32'h0001_0000, 32'h0002_0000);
    while (rises < 2 && k < 300) begin
      tick();
      k++;
      if (oDivInputReady && !prev) rises++;
      prev = oDivInputReady;
    end
    check("t6_reach_y", rises, 2);
    tick(5);
    check("t6_in_wait", {29'h0, oState}, {29'h0, S_WAIT_RESULT});
    snap_done = done_cnt;
    Reset = 1'b1;
    tick();
    check("t6_rst_flags", {28'h0, oBusy, oDone, oTimeout, oDivInputReady}, 32'h0);
    check("t6_rst_state", {29'h0, oState}, {29'h0, S_IDLE});
    check("t6_rst_results", oResultX | oResultY | oResultZ, 32'h0);
    check("t6_rst_div_ops", oDivDividend | oDivDivisor, 32'h0);
    Reset = 1'b0;
    tick(60);
    check("t6_no_done", done_cnt - snap_done, 0);
    lat = 3;
    start(3'b111, 32'h0002_0000, 32'h0001_0000, 32'hFFFE_0000, 32'h0001_0000,
          32'h0001_0000, 32'h0002_0000);
    wait_done("t6_after_done", 200);
    check("t6_after_x", oResultX, 32'h0002_0000);
    check("t6_after_y", oResultY, 32'hFFFE_0000);
    check("t6_after_z", oResultZ, 32'h0000_8000);

    // Silent divider on the MAX_WAIT=16 instance
    set_ops(3'b010, 32'h1111_2222, 32'h0001_0000, 32'h0007_0000, 32'h0001_0000,
            32'h3333_4444, 32'h0001_0000);
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    w = 0; early = 0; k = 0;
    while (!t_done && k < 100) begin
      tick();
      k++;
      if (t_state == S_WAIT_RESULT) begin
        w++;
        if (t_timeout) early++;
      end
    end
    check("t7_done", {31'h0, t_done}, 32'h1);
    check("t7_wait_cycles", w, 16);
    check("t7_no_early_timeout", early, 0);
    check("t7_timeout", {31'h0, t_timeout}, 32'h1);
    check("t7_y_zero", t_res_y, 32'h0);
    check("t7_x_pass", t_res_x, 32'h1111_2222);
    tick(3);
    check("t7_timeout_sticky", {31'h0, t_timeout}, 32'h1);
    set_ops(3'b000, 0, 0, 0, 0, 0, 0);
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    check("t7_timeout_cleared", {31'h0, t_timeout}, 32'h0);
    tick(3);

    // Zero divisor handling
    snap_hs = hs_cnt;
`ifdef DIV_ZERO_BYPASS_EN
    start(3'b111, 32'h8000_0000, 32'h0, 32'h0001_0000, 32'h0,
          32'h0009_0000, 32'h0003_0000);
    wait_done("t8_done", 200);
    tick(2);
    check("t8_x_sat_neg", oResultX, 32'hF000_0001);
    check("t8_y_sat_pos", oResultY, 32'h0FFF_FFFF);
    check("t8_z", oResultZ, 32'h0003_0000);
    check("t8_handshakes", hs_cnt - snap_hs, 1);
`else
    start(3'b001, 32'h8000_0000, 32'h0, 32'h0001_0000, 32'h0,
          32'h0009_0000, 32'h0003_0000);
    wait_done("t8_done", 200);
    tick(2);
    check("t8_x_from_divider", oResultX, 32'hFFFF_FFFF);
    check("t8_handshakes", hs_cnt - snap_hs, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
